// File: rtl/range_delay_line_pkg.sv
// rtl/range_delay_line_pkg.sv - shared constants and types for the range delay line
package range_delay_line_pkg;

  localparam int DRFM_DATA_W = 32;
  localparam int RDL_ADDR_W  = 10;

  // Offset-binary mid-scale (the "zero" sample of the DAC path)
  localparam logic [DRFM_DATA_W-1:0] OB_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    RDL_IDLE = 2'd0,
    RDL_FILL = 2'd1,
    RDL_RUN  = 2'd2
  } rdl_state_e;

  // Which source drives out_data in the cycle after a strobe
  typedef enum logic [1:0] {
    SRC_RAM    = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ZERO   = 2'd2
  } rdl_src_e;

endpackage

// File: rtl/range_delay_line_sdp_ram.sv
// rtl/range_delay_line_sdp_ram.sv - simple dual-port RAM, one write and one registered read port
module range_delay_line_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; no reset so this maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/range_delay_line.sv
// rtl/range_delay_line.sv - programmable range delay counted in input samples; RANGE_DELAY_ZERO_FILL_EN emits mid-scale while filling
module range_delay_line
  import range_delay_line_pkg::*;
#(
  parameter int DATA_W = DRFM_DATA_W,
  parameter int ADDR_W = RDL_ADDR_W
) (
  input  logic              M100CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] delay,
  input  logic              delay_load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              delay_active
);

  localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

  rdl_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] delay_r_q, delay_r_d;
  logic              out_valid_q, out_valid_d;
  rdl_src_e          src_q, src_d;
  logic [DATA_W-1:0] byp_data_q, hold_q;
  logic              delay_active_q;

  logic              active;
  logic              wr_en;
  logic              rd_fire;
  logic              fill_fire;
  logic              bypass;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_mux;

  assign active    = enable && ((state_q == RDL_FILL) || (state_q == RDL_RUN));
  assign wr_en     = active && in_valid;
  // A load strobe always restarts the fill, so it never reads under the old delay
  assign rd_fire   = wr_en && (state_q == RDL_RUN) && !delay_load;
  assign fill_fire = wr_en && ((state_q == RDL_FILL) || delay_load);
  assign bypass    = (delay_r_q == '0);
  assign rd_addr   = wr_ptr_q - delay_r_q;

  // Pointer, fill counter and delay register next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    delay_r_d  = delay_r_q;
    if (delay_load) begin
      delay_r_d = delay;
    end
    if (!active) begin
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (delay_load) begin
        // The coincident sample is the first one under the new delay
        fill_cnt_d = (wr_en && (delay != '0)) ? ADDR_W'(1) : '0;
      end else if ((state_q == RDL_FILL) && wr_en && (fill_cnt_q != delay_r_q)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  // FSM next-state: enable dominates, a load restarts the fill, fill completes on count
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = RDL_IDLE;
    end else begin
      case (state_q)
        RDL_IDLE: state_d = RDL_FILL;
        RDL_FILL: begin
          if (delay_load) begin
            state_d = RDL_FILL;
          end else if (fill_cnt_d == delay_r_q) begin
            state_d = RDL_RUN;
          end
        end
        RDL_RUN: begin
          if (delay_load) begin
            state_d = RDL_FILL;
          end
        end
        default: state_d = RDL_IDLE;
      endcase
    end
  end

  // FSM outputs: which strobes produce a sample next cycle and from where
  always_comb begin
    out_valid_d = 1'b0;
    src_d       = src_q;
    if (rd_fire) begin
      out_valid_d = 1'b1;
      src_d       = bypass ? SRC_BYPASS : SRC_RAM;
    end
`ifdef RANGE_DELAY_ZERO_FILL_EN
    else if (fill_fire) begin
      out_valid_d = 1'b1;
      src_d       = SRC_ZERO;
    end
`endif
  end

  // Control and output registers
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      state_q        <= RDL_IDLE;
      wr_ptr_q       <= '0;
      fill_cnt_q     <= '0;
      delay_r_q      <= '0;
      out_valid_q    <= 1'b0;
      src_q          <= SRC_RAM;
      byp_data_q     <= '0;
      hold_q         <= '0;
      delay_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_cnt_q     <= fill_cnt_d;
      delay_r_q      <= delay_r_d;
      out_valid_q    <= out_valid_d;
      src_q          <= src_d;
      delay_active_q <= (state_d == RDL_RUN);
      if (rd_fire && bypass) begin
        byp_data_q <= in_data;
      end
      if (out_valid_q) begin
        hold_q <= out_mux;
      end
    end
  end

  // Output mux: live source while valid, otherwise the last presented sample
  always_comb begin
    out_mux = hold_q;
    if (out_valid_q) begin
      case (src_q)
        SRC_BYPASS: out_mux = byp_data_q;
        SRC_ZERO:   out_mux = MID_SCALE;
        default:    out_mux = ram_rdata;
      endcase
    end
  end

  range_delay_line_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (M100CLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .re_i    (rd_fire && !bypass),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign out_valid    = out_valid_q;
  assign out_data     = out_mux;
  assign delay_active = delay_active_q;

endmodule

// File: tb/tb_range_delay_line.sv
// tb/tb_range_delay_line.sv - self-checking bench for range_delay_line (RANGE_DELAY_ZERO_FILL_EN aware)
module tb_range_delay_line;

  localparam logic [31:0] MID = 32'h8000_0000;

  logic        M100CLK = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  delay = '0;
  logic        delay_load = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        delay_active;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 fill, 2 run
  int          m_state = 0;
  int          m_delay = 0;
  int          m_fill = 0;
  logic [31:0] hist[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  range_delay_line dut (
    .M100CLK      (M100CLK),
    .reset        (reset),
    .enable       (enable),
    .delay        (delay),
    .delay_load   (delay_load),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .delay_active (delay_active)
  );

  always #5 M100CLK = ~M100CLK;

  task automatic model_reset();
    m_state = 0;
    m_delay = 0;
    m_fill = 0;
    hist.delete();
    exp_q.delete();
    last_exp = '0;
  endtask

  task automatic set_enable(input bit e);
    enable = e;
    @(posedge M100CLK);
    @(negedge M100CLK);
    if (!e) begin
      m_state = 0;
      m_fill = 0;
      hist.delete();
    end else if (m_state == 0) begin
      m_state = 1;
      m_fill = 0;
      hist.delete();
    end
  endtask

  task automatic load_only(input int nd);
    delay = 10'(nd);
    delay_load = 1'b1;
    @(posedge M100CLK);
    @(negedge M100CLK);
    delay_load = 1'b0;
    m_delay = nd;
    m_fill = 0;
    if (m_state != 0) m_state = 1;
  endtask

  // One strobe plus one idle clock; checks latency, data, delay_active and quiet/hold cycle
  task automatic send(input logic [31:0] d, input bit load, input int nd);
    bit          exp_v;
    bit          exp_act;
    logic [31:0] e;
    exp_v = 1'b0;
    if (load && m_state != 0) begin
      m_delay = nd;
      m_fill = (nd > 0) ? 1 : 0;
      m_state = 1;
      hist.push_back(d);
`ifdef RANGE_DELAY_ZERO_FILL_EN
      exp_q.push_back(MID);
      exp_v = 1'b1;
`endif
    end else if (m_state == 1 && m_fill != m_delay) begin
      hist.push_back(d);
      m_fill++;
`ifdef RANGE_DELAY_ZERO_FILL_EN
      exp_q.push_back(MID);
      exp_v = 1'b1;
`endif
    end else if (m_state != 0) begin
      m_state = 2;
      hist.push_back(d);
      exp_q.push_back(hist[hist.size() - 1 - m_delay]);
      exp_v = 1'b1;
    end
    exp_act = !load && (m_state == 2 || (m_state == 1 && m_fill == m_delay));

    in_valid = 1'b1;
    in_data = d;
    delay_load = load;
    delay = 10'(nd);
    @(posedge M100CLK);
    @(negedge M100CLK);
    in_valid = 1'b0;
    delay_load = 1'b0;

    checks++;
    if (out_valid !== exp_v) begin
      errors++;
      $display("FAIL latency: out_valid=%0b expected %0b (data %h)", out_valid, exp_v, d);
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious: out_data=%h with no expected sample", out_data);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL data: out_data=%h expected %h", out_data, e);
        end
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    checks++;
    if (delay_active !== exp_act) begin
      errors++;
      $display("FAIL delay_active: got %0b expected %0b", delay_active, exp_act);
    end

    @(posedge M100CLK);
    @(negedge M100CLK);
    checks++;
    if (out_valid !== 1'b0 || out_data !== last_exp) begin
      errors++;
      $display("FAIL hold: out_valid=%0b out_data=%h expected 0 / %h", out_valid, out_data, last_exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || delay_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v=%0b d=%h a=%0b expected 0/0/0", out_valid, out_data, delay_active);
    end
  endtask

  task automatic test_delay4();
    set_enable(1'b0);
    load_only(4);
    set_enable(1'b1);
    for (int k = 1; k <= 12; k++) send(32'(k), 1'b0, 4);
  endtask

  task automatic test_zero_delay();
    set_enable(1'b0);
    load_only(0);
    set_enable(1'b1);
    checks++;
    if (delay_active !== 1'b0) begin
      errors++;
      $display("FAIL zero_active_early: got %0b expected 0", delay_active);
    end
    @(posedge M100CLK);
    @(negedge M100CLK);
    checks++;
    if (delay_active !== 1'b1) begin
      errors++;
      $display("FAIL zero_active: got %0b expected 1", delay_active);
    end
    for (int k = 0; k < 8; k++) send($urandom, 1'b0, 0);
  endtask

  task automatic test_max_delay();
    set_enable(1'b0);
    load_only(1023);
    set_enable(1'b1);
    for (int k = 1; k <= 1030; k++) send(32'h1000_0000 + 32'(k), 1'b0, 1023);
  endtask

  task automatic test_reload();
    set_enable(1'b0);
    load_only(8);
    set_enable(1'b1);
    for (int k = 1; k <= 12; k++) send(32'h200 + 32'(k), 1'b0, 8);
    send(32'hA5A5_A5A5, 1'b1, 3);
    for (int k = 1; k <= 6; k++) send(32'h300 + 32'(k), 1'b0, 3);
  endtask

  task automatic test_reset_mid_run();
    set_enable(1'b0);
    load_only(2);
    set_enable(1'b1);
    for (int k = 1; k <= 5; k++) send(32'h400 + 32'(k), 1'b0, 2);
    in_valid = 1'b1;
    in_data = 32'h0000_0406;
    @(posedge M100CLK);
    #2;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %0b expected 1", out_valid);
    end
    reset = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || delay_active !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: v=%0b a=%0b d=%h expected 0/0/0", out_valid, delay_active, out_data);
    end
    @(negedge M100CLK);
    reset = 1'b1;
    model_reset();
    @(negedge M100CLK);
    load_only(2);
    set_enable(1'b1);
    for (int k = 1; k <= 6; k++) send(32'h500 + 32'(k), 1'b0, 2);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge M100CLK);
    reset = 1'b1;
    @(negedge M100CLK);
    test_reset();
    test_delay4();
    test_zero_delay();
    test_max_delay();
    test_reload();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
